// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared constants and types for the 1-to-4 stream
//               demultiplexer (channel count, payload and counter widths,
//               channel index type, per-channel FIFO state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    localparam int N_CH   = 4;
    localparam int W_DATA = 4;
    localparam int W_CNT  = 8;

    typedef logic [$clog2(N_CH)-1:0] ch_sel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/demux_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : demux_fifo2
// Description : One 2-entry channel FIFO. The head entry is shown on dout
//               while the FIFO is non-empty, and zero while it is empty.
//               A push and a pop in the same cycle both take effect.
// Ports       : clk, rst   - clock, asynchronous active-high reset
//               push, din  - write strobe and payload
//               pop        - read strobe (removes the head entry)
//               dout       - head entry (0 when empty)
//               full/empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module demux_fifo2
    import stream_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [W_DATA-1:0] din,
    output logic [W_DATA-1:0] dout,
    output logic              full,
    output logic              empty
);

    fifo_state_t       state;
    logic [W_DATA-1:0] head;
    logic [W_DATA-1:0] tail;
    logic              push_ok;
    logic              pop_ok;

    // Strobes are qualified here so the FIFO can never over- or underflow,
    // even if a caller misbehaves.
    assign push_ok = push && (state != TWO);
    assign pop_ok  = pop  && (state != EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push_ok) begin
                        head  <= din;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push_ok && pop_ok) begin
                        // Old head leaves, new word becomes the head.
                        head <= din;
                    end else if (push_ok) begin
                        tail  <= din;
                        state <= TWO;
                    end else if (pop_ok) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop_ok) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign empty = (state == EMPTY);
    assign full  = (state == TWO);
    assign dout  = empty ? '0 : head;

endmodule : demux_fifo2
`default_nettype wire

// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_4
// Description : 1-to-4 valid/ready stream demultiplexer. Each input word is
//               steered by in_sel into one of four 2-entry channel FIFOs.
//               in_ready depends only on the addressed channel's occupancy,
//               so a blocked channel never stalls traffic to the others.
// Ports       : clk, rst              - clock, async active-high reset
//               in_valid/in_ready     - upstream handshake
//               in_data, in_sel       - payload and destination channel
//               out_valid/out_ready   - per-channel handshakes (bit k)
//               out_data              - channel k payload on [4k+3:4k]
//               out_cnt               - channel k transfer count on [8k+7:8k]
// Config      : STREAM_DEMUX_1_4_CNT_EN - enables 8-bit wrapping per-channel
//               output transfer counters; otherwise out_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_4
    import stream_demux_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W_DATA-1:0]        in_data,
    input  logic [1:0]               in_sel,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*W_DATA-1:0]   out_data,
    output logic [N_CH*W_CNT-1:0]    out_cnt
);

    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] push;
    logic [N_CH-1:0] pop;
    ch_sel_t         sel;

    assign sel      = ch_sel_t'(in_sel);
    assign in_ready = ~full[sel];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign push[k]      = in_valid && in_ready && (sel == ch_sel_t'(k));
        assign pop[k]       = out_valid[k] && out_ready[k];
        assign out_valid[k] = ~empty[k];

        demux_fifo2 u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (in_data),
            .dout  (out_data[k*W_DATA +: W_DATA]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

`ifdef STREAM_DEMUX_1_4_CNT_EN
    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
        logic [W_CNT-1:0] cnt;

        // Natural binary wrap from 255 to 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (pop[k]) begin
                cnt <= cnt + W_CNT'(1);
            end
        end

        assign out_cnt[k*W_CNT +: W_CNT] = cnt;
    end
`else
    assign out_cnt = '0;
`endif

endmodule : stream_demux_1_4
`default_nettype wire
